// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: rate-coded spike train generator with shadowed per-channel rates
// Ports: clk, reset (sync, active-high), enable, load_valid/load_ready/load_ch/load_rate
//        (rate write port), x_out (registered spikes), window_done (end-of-window pulse),
//        running (high while in RUN).
module spike_rate_encoder #(
    parameter int CHANNELS = 4,
    parameter int RATE_W   = 4,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [RATE_W-1:0]   load_rate,
    output logic [CHANNELS-1:0] x_out,
    output logic                window_done,
    output logic                running
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [RATE_W-1:0] shadow [CHANNELS];
    logic [RATE_W-1:0] shadow_next [CHANNELS];
    logic [RATE_W-1:0] active [CHANNELS];
    logic [RATE_W-1:0] acc [CHANNELS];
    logic [RATE_W-1:0] cnt;
    logic              wr;
    logic              wrap;
    // writes to channels beyond CHANNELS are handshaken but discarded
    assign wr      = load_valid && load_ready && (int'(load_ch) < CHANNELS);
    assign wrap    = cnt == '1;
    assign running = state == RUN;
    // shadow including this cycle's write, so a load coinciding with a window
    // boundary or start already reaches the active rates
    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            shadow_next[i] = (wr && int'(load_ch) == i) ? load_rate : shadow[i];
    end
    always_comb begin
        state_next = enable ? RUN : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            load_ready  <= 1'b0;
            cnt         <= '0;
            x_out       <= '0;
            window_done <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                acc[i]    <= '0;
            end
        end else begin
            load_ready <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= shadow_next[i];
            if (running && enable) begin
                // carry out of the phase accumulator is the spike; acc returns to
                // zero by itself at each wrap since 2^RATE_W*r is a multiple of 2^RATE_W
                for (int i = 0; i < CHANNELS; i++)
                    {x_out[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, active[i]};
                cnt         <= cnt + 1'b1;
                window_done <= wrap;
                if (wrap)
                    for (int i = 0; i < CHANNELS; i++) active[i] <= shadow_next[i];
            end else begin
                x_out       <= '0;
                cnt         <= '0;
                window_done <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    acc[i] <= '0;
                    if (enable) active[i] <= shadow_next[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: randomized and directed check of spike_rate_encoder against a window-position model
module tb_spike_rate_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [1:0] load_ch = 2'd0;
    logic [3:0] load_rate = 4'd0;
    logic [3:0] x_out;
    logic       window_done;
    logic       running;
    spike_rate_encoder dut (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .load_ch(load_ch), .load_rate(load_rate),
        .x_out(x_out), .window_done(window_done), .running(running)
    );
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    int sh [4];
    int act [4];
    int k = 0;
    int m_run = 0;
    int m_ready = 0;
    int m_wd = 0;
    logic [3:0] m_x = 4'd0;
    int wc [4];
    int wdc;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask
    // spike number k of a window at rate r, straight from the floor rule
    function automatic bit spike(input int kk, input int r);
        return (kk * r) / 16 > ((kk - 1) * r) / 16;
    endfunction
    task automatic step(input bit rst_i, input bit en_i, input bit v_i,
                        input logic [1:0] ch_i, input logic [3:0] r_i);
        int shn [4];
        @(negedge clk);
        reset = rst_i; enable = en_i; load_valid = v_i; load_ch = ch_i; load_rate = r_i;
        @(posedge clk);
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin sh[i] = 0; act[i] = 0; end
            k = 0; m_run = 0; m_ready = 0; m_wd = 0; m_x = 4'd0;
        end else begin
            shn = sh;
            if (v_i && m_ready == 1) shn[ch_i] = int'(r_i);
            if (m_run == 1 && en_i) begin
                k++;
                for (int i = 0; i < 4; i++) m_x[i] = spike(k, act[i]);
                m_wd = (k == 16) ? 1 : 0;
                if (k == 16) begin act = shn; k = 0; end
            end else begin
                m_x = 4'd0; m_wd = 0; k = 0;
                if (en_i) act = shn;
            end
            m_run = en_i ? 1 : 0;
            m_ready = 1;
            sh = shn;
        end
        #1;
        check("x_out", 32'(x_out), 32'(m_x));
        check("window_done", 32'(window_done), m_wd);
        check("running", 32'(running), m_run);
        check("load_ready", 32'(load_ready), m_ready);
    endtask
    // 16 enabled cycles with an optional write on spike slot wk; tallies spikes
    task automatic window_count(input int wk, input logic [1:0] wch, input logic [3:0] wr);
        for (int i = 0; i < 4; i++) wc[i] = 0;
        wdc = 0;
        for (int j = 1; j <= 16; j++) begin
            step(1'b0, 1'b1, j == wk, wch, wr);
            for (int i = 0; i < 4; i++) wc[i] += int'(x_out[i]);
            wdc += int'(window_done);
        end
    endtask
    initial begin
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 2'd1, 4'd4);
        step(1'b0, 1'b0, 1'b1, 2'd2, 4'd8);
        step(1'b0, 1'b0, 1'b1, 2'd3, 4'd15);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        window_count(0, 2'd0, 4'd0);
        check("w1_ch0", wc[0], 0);
        check("w1_ch1", wc[1], 4);
        check("w1_ch2", wc[2], 8);
        check("w1_ch3", wc[3], 15);
        check("w1_done", wdc, 1);
        window_count(3, 2'd1, 4'd8);
        check("w2_ch1_old", wc[1], 4);
        window_count(5, 2'd1, 4'd2);
        check("w3_ch1_mid_write", wc[1], 8);
        window_count(16, 2'd0, 4'd5);
        check("w4_ch1_new", wc[1], 2);
        check("w4_ch0_still0", wc[0], 0);
        window_count(0, 2'd0, 4'd0);
        check("w5_ch0_wrap_write", wc[0], 5);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        check("stop_x", 32'(x_out), 0);
        check("stop_done", 32'(window_done), 0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        check("restart_k1_ch2", 32'(x_out[2]), 0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        check("restart_k2_ch2", 32'(x_out[2]), 1);
        for (int j = 0; j < 14; j++) step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        for (int w = 0; w < 4; w++) begin
            window_count(0, 2'd0, 4'd0);
            check("rep_ch0", wc[0], 5);
            check("rep_ch1", wc[1], 2);
            check("rep_ch2", wc[2], 8);
            check("rep_ch3", wc[3], 15);
            check("rep_done", wdc, 1);
        end
        step(1'b1, 1'b1, 1'b1, 2'd2, 4'd3);
        check("rst_ready", 32'(load_ready), 0);
        check("rst_x", 32'(x_out), 0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        check("post_rst_ready", 32'(load_ready), 1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        window_count(0, 2'd0, 4'd0);
        check("post_rst_ch2", wc[2], 0);
        for (int j = 0; j < 800; j++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
